// File: rtl/lagarto_l15_req_arbiter.sv
// lagarto_l15_req_arbiter
//   Shares the tile's single L1.5 request channel among NUM_REQ core-side
//   requesters (icache = 0, dcache = 1 by default) with round-robin
//   arbitration. It counts outstanding transactions per requester, routes
//   L1.5 returns back by source tag, and gives the core a drain/busy
//   handshake for fencing and reset sequencing.
//
// Ports
//   clk_i, rst_ni   core clock, asynchronous active-low reset
//   req_valid_i     per-requester valid, held with data until accepted
//   req_data_i      flattened payloads, requester i at [i*REQ_W +: REQ_W]
//   req_ready_o     one-cycle accept pulse to the granted requester
//   l15_val_o       request valid to L1.5 (registered)
//   l15_data_o      request payload to L1.5 (registered)
//   l15_src_o       source tag of the current request (threadid field)
//   l15_ack_i       L1.5 accepted the request
//   rtrn_val_i      L1.5 return valid
//   rtrn_src_i      source tag of the return
//   rtrn_val_o      decoded per-requester return valid
//   drain_i         block new grants while high
//   busy_o          request pending or any outstanding counter nonzero
//   err_o           sticky: out-of-range return tag or counter underflow
//
// Optional feature (macro LAGARTO_L15_ARB_PERF_EN)
//   perf_grant_o    NUM_REQ saturating 32-bit accepted-request counters
//   perf_stall_o    saturating count of HOLD cycles without l15_ack_i
module lagarto_l15_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int REQ_W     = 128,
  parameter int MAX_OUTST = 4,
  parameter int SRC_W     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*REQ_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     l15_val_o,
  output logic [REQ_W-1:0]         l15_data_o,
  output logic [SRC_W-1:0]         l15_src_o,
  input  logic                     l15_ack_i,
  input  logic                     rtrn_val_i,
  input  logic [SRC_W-1:0]         rtrn_src_i,
  output logic [NUM_REQ-1:0]       rtrn_val_o,
  input  logic                     drain_i,
  output logic                     busy_o,
  output logic                     err_o
`ifdef LAGARTO_L15_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]    perf_grant_o,
  output logic [31:0]              perf_stall_o
`endif
);

  localparam int               CNT_W      = 4;
  localparam logic             STATE_IDLE = 1'b0;
  localparam logic             STATE_HOLD = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SRC_W-1:0] PTR_RST    = SRC_W'(NUM_REQ - 1);

  logic                 state_r;
  logic [SRC_W-1:0]     ptr_r;
  logic [CNT_W-1:0]     cnt_r [NUM_REQ];
  logic                 err_r;

  logic [NUM_REQ-1:0]   eligible_s;
  logic [NUM_REQ-1:0]   inc_s;
  logic [NUM_REQ-1:0]   dec_s;
  logic                 grant_found_s;
  logic [SRC_W-1:0]     grant_idx_s;
  logic [REQ_W-1:0]     grant_data_s;
  logic                 ack_s;
  logic                 any_cnt_s;
  logic                 err_set_s;

  // An ack only counts while a request is actually being offered.
  assign ack_s = (state_r == STATE_HOLD) & l15_ack_i;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    assign eligible_s[k]  = req_valid_i[k] & (cnt_r[k] < CNT_MAX) & ~drain_i;
    assign req_ready_o[k] = ack_s & (l15_src_o == SRC_W'(k));
    assign rtrn_val_o[k]  = rtrn_val_i & (rtrn_src_i == SRC_W'(k));
    assign inc_s[k]       = req_ready_o[k];
    // A return against an empty counter is an error, not a wrap.
    assign dec_s[k]       = rtrn_val_o[k] & (cnt_r[k] != CNT_ZERO);
  end

  // Underflow shows up as a decoded return that was not allowed to decrement.
  assign err_set_s = (rtrn_val_i & (int'(rtrn_src_i) >= NUM_REQ))
                   | (|(rtrn_val_o & ~dec_s));

  // Round-robin pick: scan from farthest to nearest offset after ptr_r so the
  // nearest eligible requester is the one left standing.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {SRC_W{1'b0}};
    for (int off = NUM_REQ; off >= 1; off--) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (eligible_s[k] && (k == (int'(ptr_r) + off) % NUM_REQ)) begin
          grant_found_s = 1'b1;
          grant_idx_s   = SRC_W'(k);
        end else begin
          grant_found_s = grant_found_s;
          grant_idx_s   = grant_idx_s;
        end
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    grant_data_s = {REQ_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx_s == SRC_W'(k)) begin
        grant_data_s = req_data_i[k*REQ_W +: REQ_W];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // OR-reduce the outstanding counters for busy.
  always_comb begin
    any_cnt_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      any_cnt_s = any_cnt_s | (cnt_r[k] != CNT_ZERO);
    end
  end

  assign busy_o = (state_r == STATE_HOLD) | any_cnt_s;
  assign err_o  = err_r;

  // Request FSM: capture the winner in IDLE, hold it stable until acked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= STATE_IDLE;
      ptr_r      <= PTR_RST;
      l15_val_o  <= 1'b0;
      l15_data_o <= {REQ_W{1'b0}};
      l15_src_o  <= {SRC_W{1'b0}};
    end else begin
      case (state_r)
        STATE_IDLE: begin
          if (grant_found_s) begin
            state_r    <= STATE_HOLD;
            l15_val_o  <= 1'b1;
            l15_data_o <= grant_data_s;
            l15_src_o  <= grant_idx_s;
            ptr_r      <= grant_idx_s;
          end
        end
        STATE_HOLD: begin
          // drain_i is deliberately ignored here: an offered request completes.
          if (l15_ack_i) begin
            state_r   <= STATE_IDLE;
            l15_val_o <= 1'b0;
          end
        end
        default: begin
          state_r   <= STATE_IDLE;
          l15_val_o <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding counters; an ack and a return on the same cycle cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        case ({inc_s[k], dec_s[k]})
          2'b10:   cnt_r[k] <= cnt_r[k] + CNT_ONE;
          2'b01:   cnt_r[k] <= cnt_r[k] - CNT_ONE;
          default: cnt_r[k] <= cnt_r[k];
        endcase
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end
  end

`ifdef LAGARTO_L15_ARB_PERF_EN
  logic [31:0] perf_grant_r [NUM_REQ];
  logic [31:0] perf_stall_r;

  // Saturating per-requester accept counters and HOLD-stall counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        perf_grant_r[k] <= 32'd0;
      end
      perf_stall_r <= 32'd0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ready_o[k] && (perf_grant_r[k] != 32'hFFFF_FFFF)) begin
          perf_grant_r[k] <= perf_grant_r[k] + 32'd1;
        end
      end
      if ((state_r == STATE_HOLD) && !l15_ack_i && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_perf
    assign perf_grant_o[k*32 +: 32] = perf_grant_r[k];
  end
  assign perf_stall_o = perf_stall_r;
`endif

endmodule

// File: tb/tb_lagarto_l15_req_arbiter.sv
// Testbench for lagarto_l15_req_arbiter: a directed vector table, hand-written
// multi-cycle corner sequences, and randomized traffic compared each cycle
// against a transaction-level reference model of the arbiter.
module tb_lagarto_l15_req_arbiter;

  localparam int N    = 2;
  localparam int W    = 128;
  localparam int MAXO = 4;
  localparam int SW   = 2;

  localparam logic [W-1:0] DATA_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [W-1:0] DATA_B = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           l15_val;
  logic [W-1:0]   l15_data;
  logic [SW-1:0]  l15_src;
  logic           l15_ack;
  logic           rtrn_val;
  logic [SW-1:0]  rtrn_src;
  logic [N-1:0]   rtrn_val_o;
  logic           drain;
  logic           busy;
  logic           err;
`ifdef LAGARTO_L15_ARB_PERF_EN
  logic [N*32-1:0] perf_grant;
  logic [31:0]     perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending request record, per-requester outstanding counts.
  int           m_cnt [N];
  bit           m_pend;
  int           m_src;
  logic [W-1:0] m_data;
  int           m_last;
  bit           m_err;

  typedef struct {
    logic [1:0] v;
    logic       ack;
    logic       rv;
    logic [1:0] rs;
    logic       drain;
    logic       e_val;
    logic [1:0] e_src;
    logic [1:0] e_rdy;
    logic [1:0] e_rt;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  lagarto_l15_req_arbiter #(
    .NUM_REQ(N), .REQ_W(W), .MAX_OUTST(MAXO), .SRC_W(SW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .l15_val_o   (l15_val),
    .l15_data_o  (l15_data),
    .l15_src_o   (l15_src),
    .l15_ack_i   (l15_ack),
    .rtrn_val_i  (rtrn_val),
    .rtrn_src_i  (rtrn_src),
    .rtrn_val_o  (rtrn_val_o),
    .drain_i     (drain),
    .busy_o      (busy),
    .err_o       (err)
`ifdef LAGARTO_L15_ARB_PERF_EN
    ,
    .perf_grant_o(perf_grant),
    .perf_stall_o(perf_stall)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_pend = 0;
    m_src  = 0;
    m_data = '0;
    m_last = N - 1;
    m_err  = 0;
  endtask

  // Compare every DUT output with what the model says the current cycle shows.
  task automatic check_model();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rt;
    bit           e_busy;
    e_busy = m_pend;
    for (int k = 0; k < N; k++) begin
      e_rdy[k] = m_pend && l15_ack && (m_src == k);
      e_rt[k]  = rtrn_val && (int'(rtrn_src) == k);
      if (m_cnt[k] > 0) e_busy = 1;
    end
    chk("m_l15_val",  W'(l15_val),    W'(m_pend));
    chk("m_l15_data", l15_data,       m_data);
    chk("m_l15_src",  W'(l15_src),    W'(m_src));
    chk("m_ready",    W'(req_ready),  W'(e_rdy));
    chk("m_rtrn",     W'(rtrn_val_o), W'(e_rt));
    chk("m_busy",     W'(busy),       W'(e_busy));
    chk("m_err",      W'(err),        W'(m_err));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    int  old_cnt [N];
    int  idx;
    bit  done;
    for (int k = 0; k < N; k++) old_cnt[k] = m_cnt[k];
    if (rtrn_val) begin
      if (int'(rtrn_src) >= N) m_err = 1;
      else if (old_cnt[rtrn_src] == 0) m_err = 1;
      else m_cnt[rtrn_src] = m_cnt[rtrn_src] - 1;
    end
    if (m_pend) begin
      if (l15_ack) begin
        m_cnt[m_src] = m_cnt[m_src] + 1;
        m_pend = 0;
      end
    end else if (!drain) begin
      done = 0;
      for (int off = 1; off <= N; off++) begin
        idx = (m_last + off) % N;
        if (!done && req_valid[idx] && old_cnt[idx] < MAXO) begin
          done   = 1;
          m_pend = 1;
          m_src  = idx;
          m_last = idx;
          m_data = req_data[idx*W +: W];
        end
      end
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic ack, input logic rv,
                       input logic [1:0] rs, input logic dr);
    req_valid = v;
    l15_ack   = ack;
    rtrn_val  = rv;
    rtrn_src  = rs;
    drain     = dr;
    #1;
    check_model();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0; l15_ack = 1'b0; rtrn_val = 1'b0; rtrn_src = '0; drain = 1'b0;
    rst_ni = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    int         g0;
    int         g1;
    logic [1:0] exp_rdy;
    logic [1:0] rs;
    logic       rv;

    tbl[0] = '{2'b01, 1'b0, 1'b0, 2'd0, 1'b0,  1'b0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 2'd0, 1'b0,  1'b1, 2'd0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[2] = '{2'b01, 1'b0, 1'b0, 2'd0, 1'b0,  1'b1, 2'd0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[3] = '{2'b01, 1'b0, 1'b0, 2'd0, 1'b0,  1'b1, 2'd0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 1'b1, 1'b0, 2'd0, 1'b0,  1'b1, 2'd0, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{2'b00, 1'b0, 1'b0, 2'd0, 1'b0,  1'b0, 2'd0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[6] = '{2'b00, 1'b0, 1'b1, 2'd0, 1'b0,  1'b0, 2'd0, 2'b00, 2'b01, 1'b1, 1'b0};
    tbl[7] = '{2'b00, 1'b0, 1'b0, 2'd0, 1'b0,  1'b0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0};

    rst_ni = 1'b0;
    req_valid = '0; req_data = '0; l15_ack = 1'b0;
    rtrn_val = 1'b0; rtrn_src = '0; drain = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request: reset state, then A held from cycle 1 to 4, ack at 4.
    req_data = {DATA_B, DATA_A};
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].ack, tbl[i].rv, tbl[i].rs, tbl[i].drain);
      chk("tbl_val",   W'(l15_val),    W'(tbl[i].e_val));
      chk("tbl_src",   W'(l15_src),    W'(tbl[i].e_src));
      chk("tbl_ready", W'(req_ready),  W'(tbl[i].e_rdy));
      chk("tbl_rtrn",  W'(rtrn_val_o), W'(tbl[i].e_rt));
      chk("tbl_busy",  W'(busy),       W'(tbl[i].e_busy));
      chk("tbl_err",   W'(err),        W'(tbl[i].e_err));
      if (tbl[i].e_val) chk("tbl_data", l15_data, DATA_A);
      tick();
    end

    // Fairness: both valid, ack always high, returns follow each accept.
    do_reset();
    g0 = 0; g1 = 0;
    for (int c = 0; c < 32; c++) begin
      rv = (c >= 2) && (c % 2 == 0);
      rs = (c >= 2) ? 2'(((c / 2) - 1) % 2) : 2'd0;
      apply(2'b11, 1'b1, rv, rs, 1'b0);
      exp_rdy = (c % 2 == 1) ? (((c / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("fair_order", W'(req_ready), W'(exp_rdy));
      if (req_ready[0]) g0++;
      if (req_ready[1]) g1++;
      tick();
    end
    chk("fair_cnt0", W'(g0), W'(8));
    chk("fair_cnt1", W'(g1), W'(8));
    apply(2'b00, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    apply(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("fair_idle_busy", W'(busy), W'(0));
    tick();

    // Outstanding limit on requester 1, then release by one return.
    do_reset();
    req_data = {DATA_B, DATA_A};
    for (int c = 0; c <= 10; c++) begin
      apply(2'b10, 1'b1, 1'b0, 2'd0, 1'b0);
      chk("outst_val", W'(l15_val), W'((c % 2 == 1) && (c < 8)));
      tick();
    end
    apply(2'b10, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("outst_ret_val", W'(l15_val), W'(0));
    tick();
    apply(2'b10, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("outst_idle_val", W'(l15_val), W'(0));
    tick();
    apply(2'b10, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("outst_regrant_val", W'(l15_val), W'(1));
    chk("outst_regrant_src", W'(l15_src), W'(1));
    chk("outst_regrant_rdy", W'(req_ready), W'(2'b10));
    chk("outst_regrant_data", l15_data, DATA_B);
    tick();
    // Requester 1 is full again; requester 0 must still get through.
    apply(2'b11, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    apply(2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("nohol_val", W'(l15_val), W'(1));
    chk("nohol_src", W'(l15_src), W'(0));
    tick();
    apply(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();

    // Drain raised during HOLD: current request completes, no new grants.
    do_reset();
    apply(2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    apply(2'b01, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("drain_hold_val", W'(l15_val), W'(1));
    tick();
    apply(2'b01, 1'b1, 1'b0, 2'd0, 1'b1);
    chk("drain_ack_rdy", W'(req_ready), W'(2'b01));
    tick();
    for (int c = 3; c <= 6; c++) begin
      apply(2'b11, 1'b0, (c == 5), 2'd0, 1'b1);
      chk("drain_blocked_val", W'(l15_val), W'(0));
      chk("drain_busy", W'(busy), W'(c <= 5));
      tick();
    end
    apply(2'b11, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("drain_release_val", W'(l15_val), W'(0));
    tick();
    apply(2'b00, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("drain_after_val", W'(l15_val), W'(1));
    chk("drain_after_src", W'(l15_src), W'(1));
    tick();
    apply(2'b00, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();

    // Ack and return on requester 1 in the same cycle with two outstanding.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      apply(2'b10, 1'b1, 1'b0, 2'd0, 1'b0);
      tick();
    end
    apply(2'b10, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    apply(2'b10, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("simul_rdy",  W'(req_ready),  W'(2'b10));
    chk("simul_rtrn", W'(rtrn_val_o), W'(2'b10));
    tick();
    for (int c = 0; c < 2; c++) begin
      apply(2'b00, 1'b0, 1'b1, 2'd1, 1'b0);
      tick();
    end
    apply(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("simul_err",  W'(err),  W'(0));
    chk("simul_busy", W'(busy), W'(0));
    tick();
    apply(2'b00, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    apply(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("underflow_err", W'(err), W'(1));
    tick();

    // Out-of-range return tag.
    do_reset();
    apply(2'b00, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("badtag_rtrn", W'(rtrn_val_o), W'(2'b00));
    tick();
    apply(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("badtag_err", W'(err), W'(1));
    tick();

    // Asynchronous reset while a request is in HOLD with a counter nonzero.
    apply(2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    apply(2'b01, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    apply(2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    apply(2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("prerst_val", W'(l15_val), W'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_val",  W'(l15_val), W'(0));
    chk("rst_busy", W'(busy),    W'(0));
    chk("rst_err",  W'(err),     W'(0));
    chk("rst_src",  W'(l15_src), W'(0));
    model_reset();
    req_valid = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    apply(2'b00, 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    apply(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("postrst_underflow_err", W'(err), W'(1));
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int w = 0; w < (N * W) / 32; w++) req_data[w*32 +: 32] = $urandom;
      rs = 2'($urandom_range(0, 1));
      rv = ($urandom_range(0, 2) == 0) && (m_cnt[rs] > 0);
      if ($urandom_range(0, 39) == 0) begin
        rv = 1'b1;
        rs = 2'($urandom_range(0, 3));
      end
      apply(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rv, rs,
            ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lagarto_l15_req_arbiter.md
Name: lagarto_l15_req_arbiter

Overview:
- Shares the single L1.5 request channel of a tile among NUM_REQ core-side requesters (default: icache port 0, dcache port 1) using round-robin arbitration.
- Tracks outstanding transactions per requester and routes L1.5 returns back by source tag.
- Provides a drain/busy handshake so the core can fence or sequence reset before issuing further traffic.
- Sits between the Lagarto cache adapters and the L1.5 interface inside the tile core wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- REQ_W, 128, width of the flattened request payload.
- MAX_OUTST, 4, maximum outstanding transactions per requester (1..15).
- SRC_W, 2, source-tag width; must be >= clog2(NUM_REQ).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid; held with data until accepted.
- req_data_i  in  NUM_REQ*REQ_W  per-requester payload, requester i at bits [i*REQ_W +: REQ_W].
- req_ready_o  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- l15_val_o  out  1  request valid to L1.5.
- l15_data_o  out  REQ_W  registered payload to L1.5.
- l15_src_o  out  SRC_W  source tag of the current request, carried in the threadid field.
- l15_ack_i  in  1  L1.5 accepted the request.
- rtrn_val_i  in  1  L1.5 return valid.
- rtrn_src_i  in  SRC_W  source tag of the return.
- rtrn_val_o  out  NUM_REQ  decoded return valid per requester.
- drain_i  in  1  block new grants while high.
- busy_o  out  1  request pending or any counter nonzero.
- err_o  out  1  sticky: return with out-of-range tag, or return for a requester with zero outstanding.

Behaviour:
- Reset values:
  - l15_val_o=0, l15_data_o=0, l15_src_o=0, req_ready_o=0.
  - All counters 0, err_o=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- FSM IDLE:
  - eligible[i] = req_valid_i[i] & cnt[i]<MAX_OUTST & !drain_i.
  - If any requester is eligible, pick the first eligible index searching from ptr+1 with wrap.
  - Register its data into l15_data_o and its index into l15_src_o, set l15_val_o=1, ptr<=index, go to HOLD.
- FSM HOLD:
  - l15_val_o, l15_data_o and l15_src_o stay stable.
  - drain_i does not retract a request already in HOLD.
  - On l15_ack_i: req_ready_o[src]=1 for that cycle, cnt[src]++, l15_val_o<=0, go to IDLE.
  - Minimum spacing is one request every 2 cycles.
- Latency: a request valid in cycle N (arbiter in IDLE) appears on l15_val_o in N+1. An ack in cycle M gives a req_ready_o pulse in cycle M (combinational from l15_ack_i & HOLD).
- Returns:
  - rtrn_val_o[k] = rtrn_val_i & (rtrn_src_i==k), combinational.
  - cnt[k] decrements on that return.
- Simultaneous ack and return on the same counter: net zero change.
- Counter underflow: a return when cnt=0 leaves cnt at 0 and sets err_o.
- A tag >= NUM_REQ sets err_o and drives no rtrn_val_o.
- Full: a requester with cnt==MAX_OUTST is skipped. Others are still served; no head-of-line blocking.
- busy_o = (state==HOLD) | (|cnt), combinational.
- err_o clears only on reset.
- Reset mid-HOLD: all state is cleared asynchronously. Requesters must re-present their requests.
- l15_ack_i while in IDLE is ignored.

Optional Feature:
- Macro: LAGARTO_L15_ARB_PERF_EN.
- Enabled:
  - Adds output perf_grant_o [NUM_REQ*32], one saturating 32-bit accepted-request counter per requester, incremented on its req_ready_o pulse and reset to 0.
  - Adds output perf_stall_o [32], counting cycles in HOLD without l15_ack_i, saturating.
- Disabled: the ports and logic are absent, and the behaviour above is unchanged.

Test Plan:
- Single request: req_valid_i=2'b01, data A; ack 3 cycles after l15_val_o -> l15_val_o high from cycle 1 to 4 with data A and l15_src_o=0; req_ready_o[0] pulses at cycle 4; busy_o=1 until a return with tag 0.
- Fairness: both requesters continuously valid, ack every cycle it is offered -> grant order 0,1,0,1,...; each req_ready_o count equals 8 after 32 cycles.
- Outstanding limit: MAX_OUTST=4, requester 1 issues 4 requests with no returns while requester 0 is idle -> the 5th request is not granted. One return with tag 1 -> it is granted next IDLE cycle.
- Simultaneous: ack for src 1 and a return with tag 1 in the same cycle, with cnt[1]=2 -> cnt stays 2.
- Drain: drain_i raised while in HOLD -> the current request completes; no new l15_val_o while drain_i=1. busy_o falls when all counters reach 0.
- Errors and reset: return with tag 3 (NUM_REQ=2) -> err_o=1, rtrn_val_o=0. rst_ni pulsed low in HOLD -> l15_val_o=0 immediately, err_o=0, counters 0.
